operand_select: RTL and testbench

//  - Operand-fetch stage. Selects two source operands from a flattened register-file image

---
 rtl/operand_select_pkg.sv | 13 +
 rtl/operand_select_sel_mux_n.sv | 27 ++
 rtl/operand_select.sv | 110 +++++++++++
 tb/tb_operand_select.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/operand_select_pkg.sv
// Shared parameters, source-2 select encodings and data word type for the operand-fetch stage.
package operand_select_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 4;
    localparam int IDX_W  = 2;

    localparam logic SRC2_REG = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

    typedef logic [DATA_W-1:0] data_t;

endpackage : operand_select_pkg

// File: rtl/operand_select_sel_mux_n.sv
// sel_mux_n: NREGS:1 word mux over a flattened register image; an index past the last
// register selects zero so non-power-of-two register counts stay well defined.
module sel_mux_n
    import operand_select_pkg::*;
#(
    parameter int DATA_W = operand_select_pkg::DATA_W,
    parameter int NREGS  = operand_select_pkg::NREGS,
    parameter int IDX_W  = operand_select_pkg::IDX_W
) (
    input  logic [NREGS*DATA_W-1:0] iREGS,
    input  logic [IDX_W-1:0]        iIDX,
    output logic [DATA_W-1:0]       oVAL
);

    // Index decode: the default of zero covers any index with no matching register.
    always_comb begin
        oVAL = {DATA_W{1'b0}};
        for (int k = 0; k < NREGS; k++) begin
            if (iIDX == IDX_W'(k)) begin
                oVAL = iREGS[k*DATA_W +: DATA_W];
            end else begin
                oVAL = oVAL;
            end
        end
    end

endmodule : sel_mux_n

// File: rtl/operand_select.sv
// operand_select: operand-fetch stage, two register-index muxes plus an immediate select,
// registered one cycle ahead of execute. Define OPSEL_FORWARD_EN for same-cycle writeback forwarding.
module operand_select
    import operand_select_pkg::*;
#(
    parameter int DATA_W = operand_select_pkg::DATA_W,
    parameter int NREGS  = operand_select_pkg::NREGS,
    parameter int IDX_W  = operand_select_pkg::IDX_W
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [NREGS*DATA_W-1:0] iREGS,
    input  logic                    iEN,
    input  logic [IDX_W-1:0]        iSOURCE1_IDX,
    input  logic [IDX_W-1:0]        iSOURCE2_IDX,
    input  logic [DATA_W-1:0]       iIMM_VAL,
    input  logic                    iSRC2_IS_IMM,
    input  logic                    iWB_EN,
    input  logic [IDX_W-1:0]        iWB_IDX,
    input  logic [DATA_W-1:0]       iWB_VAL,
    output logic [DATA_W-1:0]       oSOURCE1_VAL,
    output logic [DATA_W-1:0]       oSOURCE2_VAL,
    output logic                    oVALID
);

    logic [DATA_W-1:0] mux1Val_s;
    logic [DATA_W-1:0] mux2RegVal_s;
    logic [DATA_W-1:0] src1Val_s;
    logic [DATA_W-1:0] src2RegVal_s;
    logic [DATA_W-1:0] src2Val_s;
    logic [DATA_W-1:0] src1Val_r;
    logic [DATA_W-1:0] src2Val_r;
    logic              valid_r;

    sel_mux_n #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .IDX_W  (IDX_W)
    ) uSrc1Mux (
        .iREGS (iREGS),
        .iIDX  (iSOURCE1_IDX),
        .oVAL  (mux1Val_s)
    );

    sel_mux_n #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .IDX_W  (IDX_W)
    ) uSrc2Mux (
        .iREGS (iREGS),
        .iIDX  (iSOURCE2_IDX),
        .oVAL  (mux2RegVal_s)
    );

`ifdef OPSEL_FORWARD_EN
    // Writeback forwarding: a value being written this cycle beats the stale register image.
    always_comb begin
        src1Val_s    = mux1Val_s;
        src2RegVal_s = mux2RegVal_s;
        if (iWB_EN && (iWB_IDX == iSOURCE1_IDX)) begin
            src1Val_s = iWB_VAL;
        end else begin
            src1Val_s = mux1Val_s;
        end
        if (iWB_EN && (iWB_IDX == iSOURCE2_IDX)) begin
            src2RegVal_s = iWB_VAL;
        end else begin
            src2RegVal_s = mux2RegVal_s;
        end
    end
`else
    logic unusedWb_s;

    assign unusedWb_s   = ^{iWB_EN, iWB_IDX, iWB_VAL};
    assign src1Val_s    = mux1Val_s;
    assign src2RegVal_s = mux2RegVal_s;
`endif

    // Source-2 select: the immediate wins outright, the register path is ignored then.
    always_comb begin
        src2Val_s = src2RegVal_s;
        case (iSRC2_IS_IMM)
            SRC2_IMM: src2Val_s = iIMM_VAL;
            SRC2_REG: src2Val_s = src2RegVal_s;
            default:  src2Val_s = src2RegVal_s;
        endcase
    end

    // Operand capture: load on enable, hold otherwise; valid is a one-cycle strobe.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            src1Val_r <= {DATA_W{1'b0}};
            src2Val_r <= {DATA_W{1'b0}};
            valid_r   <= 1'b0;
        end else if (iEN) begin
            src1Val_r <= src1Val_s;
            src2Val_r <= src2Val_s;
            valid_r   <= 1'b1;
        end else begin
            src1Val_r <= src1Val_r;
            src2Val_r <= src2Val_r;
            valid_r   <= 1'b0;
        end
    end

    assign oSOURCE1_VAL = src1Val_r;
    assign oSOURCE2_VAL = src2Val_r;
    assign oVALID       = valid_r;

endmodule : operand_select

// File: tb/tb_operand_select.sv
// Directed bench for operand_select: reset, register/immediate select, hold, same index,
// forwarding (expectation follows OPSEL_FORWARD_EN) and mid-stream reset.
module tb_operand_select;
    import operand_select_pkg::*;

    logic                    iCLK;
    logic                    iRST_N;
    logic [NREGS*DATA_W-1:0] iREGS;
    logic                    iEN;
    logic [IDX_W-1:0]        iSOURCE1_IDX;
    logic [IDX_W-1:0]        iSOURCE2_IDX;
    logic [DATA_W-1:0]       iIMM_VAL;
    logic                    iSRC2_IS_IMM;
    logic                    iWB_EN;
    logic [IDX_W-1:0]        iWB_IDX;
    logic [DATA_W-1:0]       iWB_VAL;
    logic [DATA_W-1:0]       oSOURCE1_VAL;
    logic [DATA_W-1:0]       oSOURCE2_VAL;
    logic                    oVALID;

    int totalCnt = 0;
    int badCnt   = 0;

    operand_select dut (
        .iCLK         (iCLK),
        .iRST_N       (iRST_N),
        .iREGS        (iREGS),
        .iEN          (iEN),
        .iSOURCE1_IDX (iSOURCE1_IDX),
        .iSOURCE2_IDX (iSOURCE2_IDX),
        .iIMM_VAL     (iIMM_VAL),
        .iSRC2_IS_IMM (iSRC2_IS_IMM),
        .iWB_EN       (iWB_EN),
        .iWB_IDX      (iWB_IDX),
        .iWB_VAL      (iWB_VAL),
        .oSOURCE1_VAL (oSOURCE1_VAL),
        .oSOURCE2_VAL (oSOURCE2_VAL),
        .oVALID       (oVALID)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                            input logic ev);
        checkVal({tag, ".src1"},  32'(oSOURCE1_VAL), 32'(e1));
        checkVal({tag, ".src2"},  32'(oSOURCE2_VAL), 32'(e2));
        checkVal({tag, ".valid"}, 32'(oVALID),       32'(ev));
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    logic [7:0] fwdExp;

    initial begin
        iRST_N       = 1'b0;
        iREGS        = {8'd40, 8'd30, 8'd20, 8'd10};
        iEN          = 1'b0;
        iSOURCE1_IDX = 2'd0;
        iSOURCE2_IDX = 2'd0;
        iIMM_VAL     = 8'd0;
        iSRC2_IS_IMM = 1'b0;
        iWB_EN       = 1'b0;
        iWB_IDX      = 2'd0;
        iWB_VAL      = 8'd0;

        // Reset held, then released with no capture
        #12;
        checkOut("reset_held", 8'd0, 8'd0, 1'b0);
        iRST_N = 1'b1;
        tick();
        checkOut("after_release", 8'd0, 8'd0, 1'b0);

        // Register select
        iSOURCE1_IDX = 2'd2;
        iSOURCE2_IDX = 2'd1;
        iEN          = 1'b1;
        tick();
        checkOut("reg_select", 8'd30, 8'd20, 1'b1);

        // Immediate overrides src2 index
        iSOURCE2_IDX = 2'd3;
        iIMM_VAL     = 8'd99;
        iSRC2_IS_IMM = 1'b1;
        tick();
        checkOut("immediate", 8'd30, 8'd99, 1'b1);

        // Hold while inputs change
        iEN          = 1'b0;
        iREGS        = {8'd1, 8'd2, 8'd3, 8'd4};
        iSOURCE1_IDX = 2'd0;
        iIMM_VAL     = 8'd7;
        tick();
        checkOut("hold1", 8'd30, 8'd99, 1'b0);
        tick();
        checkOut("hold2", 8'd30, 8'd99, 1'b0);

        // Same index on both sources
        iREGS        = {8'd40, 8'd30, 8'd20, 8'hFF};
        iSOURCE1_IDX = 2'd0;
        iSOURCE2_IDX = 2'd0;
        iSRC2_IS_IMM = 1'b0;
        iEN          = 1'b1;
        tick();
        checkOut("same_idx", 8'd255, 8'd255, 1'b1);

        // Writeback forwarding on src1; src2 reads an unrelated register
        iREGS        = {8'd40, 8'd30, 8'd20, 8'd10};
        iWB_EN       = 1'b1;
        iWB_IDX      = 2'd1;
        iWB_VAL      = 8'd77;
        iSOURCE1_IDX = 2'd1;
        iSOURCE2_IDX = 2'd2;
`ifdef OPSEL_FORWARD_EN
        fwdExp = 8'd77;
`else
        fwdExp = 8'd20;
`endif
        tick();
        checkOut("forward", fwdExp, 8'd30, 1'b1);

        // Immediate still beats a forwarded src2
        iSOURCE2_IDX = 2'd1;
        iIMM_VAL     = 8'd5;
        iSRC2_IS_IMM = 1'b1;
        tick();
        checkOut("fwd_imm_prio", fwdExp, 8'd5, 1'b1);

        // Mid-cycle reset with a capture pending
        iWB_EN       = 1'b0;
        iSRC2_IS_IMM = 1'b0;
        iSOURCE1_IDX = 2'd3;
        iSOURCE2_IDX = 2'd2;
        #2;
        iRST_N = 1'b0;
        #1;
        checkOut("reset_mid", 8'd0, 8'd0, 1'b0);
        tick();
        checkOut("reset_lost_capture", 8'd0, 8'd0, 1'b0);
        iRST_N = 1'b1;
        iEN    = 1'b0;
        tick();
        checkOut("post_reset_idle", 8'd0, 8'd0, 1'b0);
        iEN = 1'b1;
        tick();
        checkOut("post_reset_capture", 8'd40, 8'd30, 1'b1);
        iEN = 1'b0;
        tick();
        checkOut("strobe_drop", 8'd40, 8'd30, 1'b0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule : tb_operand_select
